// File: rtl/cu_pkg.sv
// Shared CU package: default datapath sizes and a constant-foldable clog2
// used to size pointers and the occupancy counter.
package cu_pkg;

    localparam int CU_DATA_W     = 4;
    localparam int CU_FIFO_DEPTH = 4;

    // Smallest r with 2**r >= n; returns 0 for n <= 1.
    function automatic int cu_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cu_wrap_ptr.sv
// Modulo-DEPTH pointer with increment enable and synchronous clear.
// DEPTH is a power of two, so wrap is the natural overflow of AW bits.
module cu_wrap_ptr
    import cu_pkg::*;
#(
    parameter int DEPTH = CU_FIFO_DEPTH,
    parameter int AW    = cu_clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] ptr_q, ptr_d;

    // Clear wins over increment so a flush discards the same-cycle access.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i)      ptr_d = '0;
        else if (inc_i) ptr_d = ptr_q + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/cu_reg_fifo.sv
// Register-based first-word-fall-through FIFO with valid/ready on both sides,
// occupancy output and synchronous flush. Define CU_FIFO_ERR_EN for sticky
// overflow/underflow flags.
module cu_reg_fifo
    import cu_pkg::*;
#(
    parameter  int W     = CU_DATA_W,
    parameter  int DEPTH = CU_FIFO_DEPTH,
    localparam int CW    = cu_clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  io_enq_data,
    input  logic          io_enq_valid,
    output logic          io_enq_ready,
    output logic [W-1:0]  io_deq_data,
    output logic          io_deq_valid,
    input  logic          io_deq_ready,
    input  logic          io_flush,
`ifdef CU_FIFO_ERR_EN
    output logic [CW-1:0] io_count,
    output logic          io_err_overflow,
    output logic          io_err_underflow
`else
    output logic [CW-1:0] io_count
`endif
);

    localparam int AW = cu_clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty, enq_fire, deq_fire;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign enq_fire = io_enq_valid & ~full;
    assign deq_fire = io_deq_ready & ~empty;

    cu_wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clr_i (io_flush),
        .inc_i (enq_fire),
        .ptr_o (wr_ptr)
    );

    cu_wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clr_i (io_flush),
        .inc_i (deq_fire),
        .ptr_o (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        if (io_flush) begin
            count_d = '0;
        end else begin
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (enq_fire && !io_flush && !reset) mem_q[wr_ptr] <= io_enq_data;
    end

    assign io_deq_data  = mem_q[rd_ptr];
    assign io_deq_valid = ~empty;
    assign io_enq_ready = ~full;
    assign io_count     = count_q;

`ifdef CU_FIFO_ERR_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    // Sticky until reset; flush deliberately leaves them alone.
    always_comb begin
        ovf_d = ovf_q | (io_enq_valid & full);
        unf_d = unf_q | (io_deq_ready & empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign io_err_overflow  = ovf_q;
    assign io_err_underflow = unf_q;
`endif

endmodule

// File: tb/tb_cu_reg_fifo.sv
// Self-checking bench for cu_reg_fifo (W=4, DEPTH=4) against a queue model.
module tb_cu_reg_fifo;

    localparam int W     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          reset, enq_valid, deq_ready, flush;
    logic [W-1:0]  enq_data;
    logic          enq_ready, deq_valid;
    logic [W-1:0]  deq_data;
    logic [CW-1:0] count;
    logic          err_ovf, err_unf;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] q[$];
    bit           m_ovf, m_unf;

    always #5 clk = ~clk;

    cu_reg_fifo #(.W(W), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .io_enq_data      (enq_data),
        .io_enq_valid     (enq_valid),
        .io_enq_ready     (enq_ready),
        .io_deq_data      (deq_data),
        .io_deq_valid     (deq_valid),
        .io_deq_ready     (deq_ready),
        .io_flush         (flush),
`ifdef CU_FIFO_ERR_EN
        .io_count         (count),
        .io_err_overflow  (err_ovf),
        .io_err_underflow (err_unf)
`else
        .io_count         (count)
`endif
    );

`ifndef CU_FIFO_ERR_EN
    assign err_ovf = 1'b0;
    assign err_unf = 1'b0;
`endif

    // Apply the current inputs to the model, then advance one clock.
    task automatic tick();
        bit full, empty;
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        if (reset) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (enq_valid && full)  m_ovf = 1;
            if (deq_ready && empty) m_unf = 1;
            if (flush) q.delete();
            else begin
                if (deq_ready && !empty) void'(q.pop_front());
                if (enq_valid && !full)  q.push_back(enq_data);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        enq_valid = 0; deq_ready = 0; flush = 0; enq_data = '0;
    endtask

    task automatic test_reset();
        reset = 1; idle();
        tick(); tick();
        total++; if (count !== 0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (deq_valid !== 0) begin bad++; $display("FAIL reset_valid: got %0b want 0", deq_valid); end
        total++; if (enq_ready !== 1) begin bad++; $display("FAIL reset_ready: got %0b want 1", enq_ready); end
`ifdef CU_FIFO_ERR_EN
        total++; if (err_ovf !== 0 || err_unf !== 0) begin bad++; $display("FAIL reset_err: got %0b%0b want 00", err_ovf, err_unf); end
`endif
        reset = 0;
    endtask

    task automatic test_order();
        logic [W-1:0] exp;
        idle();
        for (int i = 1; i <= 3; i++) begin
            enq_valid = 1; enq_data = W'(i); tick();
        end
        enq_valid = 0;
        total++; if (count !== 3) begin bad++; $display("FAIL order_count: got %0d want 3", count); end
        deq_ready = 1;
        for (int i = 1; i <= 3; i++) begin
            exp = W'(i);
            total++;
            if (deq_valid !== 1 || deq_data !== exp) begin
                bad++; $display("FAIL order_read%0d: got v=%0b d=%0h want v=1 d=%0h", i, deq_valid, deq_data, exp);
            end
            tick();
        end
        total++; if (deq_valid !== 0) begin bad++; $display("FAIL order_empty: got %0b want 0", deq_valid); end
        idle();
    endtask

    task automatic test_full();
        logic [W-1:0] exp;
        idle();
        for (int i = 0; i < 4; i++) begin
            enq_valid = 1; enq_data = W'(4'hA + i); tick();
        end
        enq_data = 4'hE;
        total++; if (enq_ready !== 0) begin bad++; $display("FAIL full_ready: got %0b want 0", enq_ready); end
        tick();
        total++; if (count !== 4) begin bad++; $display("FAIL full_drop: got %0d want 4", count); end
        // Full with reader active: dequeue happens, the offered word does not enter.
        enq_data = 4'hF; deq_ready = 1;
        total++; if (deq_data !== 4'hA) begin bad++; $display("FAIL full_head: got %0h want a", deq_data); end
        tick();
        enq_valid = 0;
        total++; if (count !== 3 || enq_ready !== 1) begin bad++; $display("FAIL full_nopass: got c=%0d r=%0b want c=3 r=1", count, enq_ready); end
        for (int i = 1; i < 4; i++) begin
            exp = W'(4'hA + i);
            total++;
            if (deq_valid !== 1 || deq_data !== exp) begin
                bad++; $display("FAIL full_drain%0d: got v=%0b d=%0h want v=1 d=%0h", i, deq_valid, deq_data, exp);
            end
            tick();
        end
        total++; if (deq_valid !== 0) begin bad++; $display("FAIL full_empty: got %0b want 0", deq_valid); end
`ifdef CU_FIFO_ERR_EN
        total++; if (err_ovf !== 1) begin bad++; $display("FAIL full_ovf: got %0b want 1", err_ovf); end
`endif
        idle();
    endtask

    task automatic test_simultaneous();
        idle();
        for (int i = 0; i < 2; i++) begin
            enq_valid = 1; enq_data = W'($urandom_range(0, 15)); tick();
        end
        deq_ready = 1;
        for (int i = 0; i < 10; i++) begin
            enq_data = W'($urandom_range(0, 15));
            total++;
            if (deq_valid !== 1 || deq_data !== q[0]) begin
                bad++; $display("FAIL simul_data%0d: got v=%0b d=%0h want v=1 d=%0h", i, deq_valid, deq_data, q[0]);
            end
            tick();
            total++; if (count !== 2) begin bad++; $display("FAIL simul_count%0d: got %0d want 2", i, count); end
        end
        enq_valid = 0;
        while (q.size() != 0) tick();
        idle();
    endtask

    task automatic test_flush();
        idle();
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1; enq_data = W'(i + 3); tick();
        end
        total++; if (count !== 3) begin bad++; $display("FAIL flush_pre: got %0d want 3", count); end
        flush = 1; enq_data = 4'h9; deq_ready = 1;
        tick();
        flush = 0; deq_ready = 0; enq_valid = 0;
        total++; if (count !== 0 || deq_valid !== 0) begin bad++; $display("FAIL flush_clear: got c=%0d v=%0b want c=0 v=0", count, deq_valid); end
        enq_valid = 1; enq_data = 4'h7; tick(); enq_valid = 0;
        total++; if (deq_valid !== 1 || deq_data !== 4'h7) begin bad++; $display("FAIL flush_after: got v=%0b d=%0h want v=1 d=7", deq_valid, deq_data); end
        deq_ready = 1; tick();
        idle();
    endtask

    task automatic test_underflow();
        idle();
        deq_ready = 1; tick(); tick();
        total++; if (count !== 0 || deq_valid !== 0) begin bad++; $display("FAIL unf_state: got c=%0d v=%0b want c=0 v=0", count, deq_valid); end
        deq_ready = 0; enq_valid = 1; enq_data = 4'h5; tick(); enq_valid = 0;
        total++; if (deq_data !== 4'h5 || count !== 1) begin bad++; $display("FAIL unf_noptr: got d=%0h c=%0d want d=5 c=1", deq_data, count); end
`ifdef CU_FIFO_ERR_EN
        total++; if (err_unf !== 1) begin bad++; $display("FAIL unf_flag: got %0b want 1", err_unf); end
        flush = 1; tick(); flush = 0;
        total++; if (err_unf !== 1) begin bad++; $display("FAIL unf_hold: got %0b want 1", err_unf); end
        reset = 1; tick(); reset = 0;
        total++; if (err_unf !== 0) begin bad++; $display("FAIL unf_reset: got %0b want 0", err_unf); end
`else
        flush = 1; tick(); flush = 0;
`endif
        idle();
    endtask

    task automatic test_midstream_reset();
        idle();
        for (int i = 0; i < 2; i++) begin
            enq_valid = 1; enq_data = W'(i + 1); tick();
        end
        enq_valid = 0; reset = 1; tick(); reset = 0;
        total++; if (deq_valid !== 0 || count !== 0) begin bad++; $display("FAIL midrst: got v=%0b c=%0d want v=0 c=0", deq_valid, count); end
        idle();
    endtask

    task automatic test_random();
        int unsigned want_cnt;
        idle();
        for (int i = 0; i < 400; i++) begin
            enq_valid = ($urandom_range(0, 99) < 60);
            deq_ready = ($urandom_range(0, 99) < 50);
            flush     = ($urandom_range(0, 99) < 3);
            enq_data  = W'($urandom_range(0, 15));
            want_cnt  = q.size();
            total++;
            if (count !== CW'(want_cnt) || deq_valid !== (want_cnt != 0) || enq_ready !== (want_cnt != DEPTH)) begin
                bad++; $display("FAIL rand_state%0d: got c=%0d v=%0b r=%0b want c=%0d", i, count, deq_valid, enq_ready, want_cnt);
            end
            if (want_cnt != 0) begin
                total++;
                if (deq_data !== q[0]) begin bad++; $display("FAIL rand_data%0d: got %0h want %0h", i, deq_data, q[0]); end
            end
`ifdef CU_FIFO_ERR_EN
            total++;
            if (err_ovf !== m_ovf || err_unf !== m_unf) begin
                bad++; $display("FAIL rand_err%0d: got %0b%0b want %0b%0b", i, err_ovf, err_unf, m_ovf, m_unf);
            end
`endif
            tick();
        end
        idle();
    endtask

    initial begin
        reset = 1; idle();
        @(negedge clk);
        test_reset();
        test_order();
        test_full();
        test_simultaneous();
        test_flush();
        test_underflow();
        test_midstream_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
